// File: rtl/d_flip_flop_pkg.sv
// Shared constants and counter next-state helper for the stopwatch slice.
// Latency: n/a (types and functions only). Backpressure: n/a.
package d_flip_flop_pkg;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] COUNTER_RESET = '0;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_COUNT = 2'd1,
    OP_LOAD  = 2'd2
  } cnt_op_t;

  function automatic logic [CNT_W-1:0] next_count(input cnt_op_t op,
                                                  input logic [CNT_W-1:0] cur,
                                                  input logic [CNT_W-1:0] din);
    logic [CNT_W-1:0] nxt;
    nxt = cur;
    case (op)
      OP_LOAD:  nxt = din;
      OP_COUNT: nxt = cur + 1'b1;
      default:  nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/d_flip_flop_if.sv
// Counter control/data bundle: load/count strobes, parallel load value, count out.
// Latency: wires only. Backpressure: none, the counter accepts every cycle.
interface d_flip_flop_if;
  import d_flip_flop_pkg::*;

  logic             load;
  logic             count;
  logic [CNT_W-1:0] din;
  logic [CNT_W-1:0] q;

  modport master (output load, output count, output din, input q);
  modport slave  (input load, input count, input din, output q);

endinterface

// File: rtl/d_flip_flop_counter.sv
// 4-bit load/count counter built from one d_flip_flop per bit.
// Latency: one cycle from load/count to q. Backpressure: none.
module d_flip_flop_counter
  import d_flip_flop_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  d_flip_flop_if.slave    bus
);

  cnt_op_t          op;
  logic [CNT_W-1:0] nxt;
  logic [CNT_W-1:0] cur;

  // Load takes priority over count.
  always_comb begin
    op = OP_HOLD;
    if (bus.load) begin
      op = OP_LOAD;
    end else if (bus.count) begin
      op = OP_COUNT;
    end
    nxt = next_count(op, cur, bus.din);
  end

  for (genvar i = 0; i < CNT_W; i++) begin : g_bit
    d_flip_flop #(
      .WIDTH       (1),
      .RESET_VALUE (COUNTER_RESET[i]),
      .INIT_VALUE  (1'b0)
    ) u_ff (
      .d   (nxt[i]),
      .clk (clk),
      .q   (cur[i]),
      .rst (rst),
      .en  (1'b1)
    );
  end

  assign bus.q = cur;

endmodule

// File: rtl/d_flip_flop.sv
// D-type storage bank with synchronous reset and clock enable.
// Latency: one cycle from d to q. Backpressure: none; en=0 simply holds q.
module d_flip_flop #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] INIT_VALUE  = {WIDTH{1'b0}}
) (
  input  logic [WIDTH-1:0] d,
  input  logic             clk,
  output logic [WIDTH-1:0] q,
  input  logic             rst,
  input  logic             en
);

  // Start-up value comes from the declaration so no reset pulse is needed.
  logic [WIDTH-1:0] q_r = INIT_VALUE;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= RESET_VALUE;
    end else if (en) begin
      q_r <= d;
    end
  end

  assign q = q_r;

endmodule

// File: tb/tb_d_flip_flop.sv
// Scoreboard bench: scalar flop, 4-bit flop with reset value A, and the counter slice.
module tb_d_flip_flop;

  logic       clk;
  logic       d1, rst1, en1, q1;
  logic [3:0] d4, q4;
  logic       rst4, en4;
  logic       rstc;

  d_flip_flop_if bus_if ();

  d_flip_flop u_dut (
    .d   (d1),
    .clk (clk),
    .q   (q1),
    .rst (rst1),
    .en  (en1)
  );

  d_flip_flop #(
    .WIDTH       (4),
    .RESET_VALUE (4'hA),
    .INIT_VALUE  (4'h0)
  ) u_dut4 (
    .d   (d4),
    .clk (clk),
    .q   (q4),
    .rst (rst4),
    .en  (en4)
  );

  d_flip_flop_counter u_cnt (
    .clk (clk),
    .rst (rstc),
    .bus (bus_if.slave)
  );

  typedef struct {
    logic       e1;
    logic [3:0] e4;
    logic [3:0] ec;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  logic       m1 = 1'b0;
  logic [3:0] m4 = 4'h0;
  int         mc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: apply the next-edge rules to the current inputs, queue the
  // result, then move to the following falling edge.
  task automatic tick();
    exp_t e;
    if (rst1) m1 = 1'b0;
    else if (en1) m1 = d1;
    if (rst4) m4 = 4'hA;
    else if (en4) m4 = d4;
    if (rstc) mc = 0;
    else if (bus_if.load) mc = int'(bus_if.din);
    else if (bus_if.count) mc = (mc + 1) % 16;
    e.e1 = m1;
    e.e4 = m4;
    e.ec = 4'(mc);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("q1", {3'b0, q1}, {3'b0, e.e1});
        chk("q4", q4, e.e4);
        chk("cnt", bus_if.q, e.ec);
      end
    end
  end

  initial begin
    int guard;
    d1 = 1'b1; en1 = 1'b1; rst1 = 1'b0;
    d4 = 4'h0; en4 = 1'b0; rst4 = 1'b0;
    rstc = 1'b0;
    bus_if.load = 1'b0; bus_if.count = 1'b0; bus_if.din = 4'h0;

    // Power-up: all outputs at INIT_VALUE before the first edge.
    #1;
    chk("init_q1", {3'b0, q1}, 4'h0);
    chk("init_q4", q4, 4'h0);
    chk("init_cnt", bus_if.q, 4'h0);
    #3;
    chk("pre_edge_q1", {3'b0, q1}, 4'h0);
    tick();

    // Capture with one cycle of latency.
    d1 = 1'b0; tick();
    d1 = 1'b1; tick();
    d1 = 1'b1; tick();
    d1 = 1'b0; tick();

    // Glitches between edges do not reach q.
    d1 = 1'b1; tick();
    d1 = 1'b0; #1 d1 = 1'b1; #1 d1 = 1'b0; #1;
    chk("glitch_hold", {3'b0, q1}, 4'h1);
    d1 = 1'b1; tick();

    // Reset raised mid-cycle waits for the edge.
    rst1 = 1'b1; #2;
    chk("rst_mid_hold", {3'b0, q1}, 4'h1);
    tick();
    rst1 = 1'b0; d1 = 1'b1; tick();

    // Reset beats enable; en=0 holds through d toggling.
    rst1 = 1'b1; en1 = 1'b1; d1 = 1'b1; tick();
    rst1 = 1'b0; tick();
    en1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d1 = ~d1; tick();
    end
    en1 = 1'b1;

    // Wide instance with non-zero reset value.
    rst4 = 1'b1; tick();
    rst4 = 1'b0; en4 = 1'b1; d4 = 4'h5; tick();
    en4 = 1'b0; d4 = 4'hF; tick();

    // Counter integration: full wrap, load, reset.
    bus_if.count = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    bus_if.load = 1'b1; bus_if.din = 4'h9; tick();
    bus_if.load = 1'b0; tick();
    rstc = 1'b1; tick();
    rstc = 1'b0; tick();

    // Randomized traffic on all three instances.
    for (int i = 0; i < 400; i++) begin
      d1 = 1'($urandom);
      en1 = 1'($urandom);
      rst1 = ($urandom_range(0, 9) == 0);
      d4 = 4'($urandom);
      en4 = 1'($urandom);
      rst4 = ($urandom_range(0, 9) == 0);
      rstc = ($urandom_range(0, 19) == 0);
      bus_if.load = ($urandom_range(0, 7) == 0);
      bus_if.count = 1'($urandom);
      bus_if.din = 4'($urandom);
      tick();
    end

    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      bad++;
      $display("FAIL drain act=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
